// File: rtl/dmem_arbiter_pkg.sv
// Shared types and encodings for the two-port data-memory arbiter.
package dmem_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    // store_type encodings (11 is passed through; memory ignores it)
    localparam logic [1:0] ST_SB   = 2'b00;
    localparam logic [1:0] ST_SH   = 2'b01;
    localparam logic [1:0] ST_SW   = 2'b10;
    localparam logic [1:0] ST_NONE = 2'b11;

    // load_type encodings
    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b010;
    localparam logic [2:0] LT_LBU = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester ports (p0 = core MEM stage, p1 = loader/debug) and memory command bus.
interface dmem_arbiter_if;
    import dmem_pkg::*;

    logic              p0_req;
    logic              p0_we;
    logic [1:0]        p0_store_type;
    logic [2:0]        p0_load_type;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_ready;
    logic              p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic [1:0]        p1_store_type;
    logic [2:0]        p1_load_type;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_ready;
    logic              p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;

    logic              mem_write;
    logic [1:0]        mem_store_type;
    logic [2:0]        mem_load_type;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // arbiter side
    modport slave (
        input  p0_req, p0_we, p0_store_type, p0_load_type, p0_addr, p0_wdata,
        output p0_ready, p0_rvalid, p0_rdata,
        input  p1_req, p1_we, p1_store_type, p1_load_type, p1_addr, p1_wdata,
        output p1_ready, p1_rvalid, p1_rdata,
        output mem_write, mem_store_type, mem_load_type, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // requesters plus memory side
    modport master (
        output p0_req, p0_we, p0_store_type, p0_load_type, p0_addr, p0_wdata,
        input  p0_ready, p0_rvalid, p0_rdata,
        output p1_req, p1_we, p1_store_type, p1_load_type, p1_addr, p1_wdata,
        input  p1_ready, p1_rvalid, p1_rdata,
        input  mem_write, mem_store_type, mem_load_type, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way picker: round-robin on ties, or fixed priority (port 0) when ROUND_ROBIN=0.
module rr_arb2 #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_gnt
);

    logic r_last;   // 1 = port 1 was granted last

    // single requester always wins; a tie goes to the port not granted last
    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            if (i_req == 2'b11)
                o_gnt = ((ROUND_ROBIN != 0) && !r_last) ? 2'b10 : 2'b01;
            else
                o_gnt = i_req;
        end
    end

    // remember the latest winner; reset value lets port 0 take the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_last <= 1'b1;
        else if (|o_gnt)
            r_last <= o_gnt[1];
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: stores complete in one cycle, loads hold the
// bus for one extra cycle while the memory returns the extended read word.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus,
    output logic           busy
);

    state_t            r_state;
    state_t            w_next;
    logic              r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_lt;

    logic [1:0]        w_gnt;
    logic              w_any;
    logic              w_en;
    logic              w_we;
    logic [1:0]        w_st;
    logic [2:0]        w_lt;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_load_acc;

    // arbitration only in IDLE and never while reset is held
    assign w_en = (r_state == IDLE) && rst_n;

    rr_arb2 #(.ROUND_ROBIN(ROUND_ROBIN)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .i_req ({bus.p1_req, bus.p0_req}),
        .i_en  (w_en),
        .o_gnt (w_gnt)
    );

    assign w_any      = |w_gnt;
    assign w_we       = w_gnt[1] ? bus.p1_we         : bus.p0_we;
    assign w_st       = w_gnt[1] ? bus.p1_store_type : bus.p0_store_type;
    assign w_lt       = w_gnt[1] ? bus.p1_load_type  : bus.p0_load_type;
    assign w_addr     = w_gnt[1] ? bus.p1_addr       : bus.p0_addr;
    assign w_wdata    = w_gnt[1] ? bus.p1_wdata      : bus.p0_wdata;
    assign w_load_acc = w_any && !w_we;

    // state register; reset aborts any load in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // next state: an accepted load parks us in RD_WAIT for exactly one cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_load_acc) w_next = RD_WAIT;
            RD_WAIT: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // capture owner and read command so the memory sees it again in RD_WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id   <= 1'b0;
            r_addr <= '0;
            r_lt   <= 3'b000;
        end else if (w_load_acc) begin
            r_id   <= w_gnt[1];
            r_addr <= w_addr;
            r_lt   <= w_lt;
        end
    end

    // outputs: pass winner straight through in IDLE, return read data in RD_WAIT
    always_comb begin
        bus.mem_write      = 1'b0;
        bus.mem_addr       = '0;
        bus.mem_store_type = ST_SW;
        bus.mem_load_type  = LT_LW;
        bus.mem_wdata      = '0;
        bus.p0_ready       = 1'b0;
        bus.p1_ready       = 1'b0;
        bus.p0_rvalid      = 1'b0;
        bus.p1_rvalid      = 1'b0;
        bus.p0_rdata       = '0;
        bus.p1_rdata       = '0;
        busy               = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    bus.p0_ready       = w_gnt[0];
                    bus.p1_ready       = w_gnt[1];
                    bus.mem_write      = w_we;
                    bus.mem_addr       = w_addr;
                    bus.mem_store_type = w_st;
                    bus.mem_load_type  = w_lt;
                    bus.mem_wdata      = w_wdata;
                end
            end
            RD_WAIT: begin
                busy              = 1'b1;
                bus.mem_addr      = r_addr;
                bus.mem_load_type = r_lt;
                if (r_id) begin
                    bus.p1_rvalid = 1'b1;
                    bus.p1_rdata  = bus.mem_rdata;
                end else begin
                    bus.p0_rvalid = 1'b1;
                    bus.p0_rdata  = bus.mem_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ROUND_ROBIN, default 1, meaning 1 = round-robin between ports and 0 = fixed priority with port 0 highest.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports pN_req  input  1  request from port N (N=0 core MEM stage, N=1 loader/debug).
REQ-005 SHALL have ports pN_we  input  1  request type, 1 = store and 0 = load.
REQ-006 SHALL have ports pN_store_type  input  2  00 = SB, 01 = SH, 10 = SW.
REQ-007 SHALL have ports pN_load_type  input  3  000 = LB, 001 = LH, 010 = LW, 011 = LBU, 100 = LHU.
REQ-008 SHALL have ports pN_addr  input  12  byte address.
REQ-009 SHALL have ports pN_wdata  input  32  store data.
REQ-010 SHALL have ports pN_ready  output  1  request accepted this cycle.
REQ-011 SHALL have ports pN_rvalid  output  1  load data valid this cycle.
REQ-012 SHALL have ports pN_rdata  output  32  extended load data.
REQ-013 SHALL have ports mem_write  output  1, mem_store_type  output  2, mem_load_type  output  3, mem_addr  output  12, mem_wdata  output  32: the data memory command.
REQ-014 SHALL have port mem_rdata  input  32  extended read data; the memory registers its read word, extends it combinationally using mem_addr[1:0] and mem_load_type, and returns it one cycle after the address is presented.
REQ-015 SHALL have port busy  output  1  high while in RD_WAIT.

Function
REQ-016 SHALL implement two states: IDLE and RD_WAIT.
REQ-017 SHALL use this handshake: a transfer occurs when pN_req and pN_ready are both high; the requester holds all request fields stable until ready.
REQ-018 IDLE, no request: SHALL drive mem_write=0, mem_addr=0, mem_store_type=10, mem_load_type=010, mem_wdata=0, and all pN_ready=0.
REQ-019 IDLE, any request: SHALL select one winner, assert its pN_ready combinationally in the same cycle, and pass its fields straight through to the mem_* outputs.
REQ-020 Winner is a store: SHALL assert mem_write=1, remain in IDLE, and give a throughput of one store per cycle.
REQ-021 Winner is a load: SHALL keep mem_write=0, register the winner id, addr and load_type, and move to RD_WAIT.
REQ-022 RD_WAIT: SHALL drive mem_addr and mem_load_type from the registered values, mem_write=0, assert rvalid for the owning port only, set its rdata = mem_rdata, deassert both readys, and return to IDLE.
REQ-023 Load latency from accept to rvalid SHALL be exactly 1 cycle; load throughput SHALL be one per 2 cycles.
REQ-024 pN_rdata SHALL be 0 whenever pN_rvalid=0.
REQ-025 Arbitration with ROUND_ROBIN=1 and both requesting: SHALL grant the port not granted last; a single requester always wins; last_grant updates on every grant.
REQ-026 Arbitration with ROUND_ROBIN=0: port 0 SHALL win whenever it requests.
REQ-027 A request arriving during RD_WAIT SHALL wait, not be dropped, and be arbitrated in the following IDLE cycle.
REQ-028 store_type 11 SHALL be forwarded unchanged (memory writes nothing); addresses SHALL be forwarded unchanged with no alignment checking.

Reset
REQ-029 rst_n low SHALL asynchronously force state=IDLE, last_grant=1 (port 0 wins the first tie), and all registered id/addr/load_type to 0.
REQ-030 During reset, outputs SHALL take their IDLE no-request values, with busy=0, rvalid=0 and rdata=0.
REQ-031 Reset asserted in RD_WAIT SHALL abort the load with no rvalid; the requester reissues it.

Structure
REQ-032 Package dmem_pkg SHALL hold the state enum (IDLE, RD_WAIT) and the store_type and load_type encoding constants.
REQ-033 SHALL contain one sub-module, rr_arb2, a two-way round-robin picker holding last_grant, with ROUND_ROBIN bypass.

Verification
REQ-034 p0 LW at addr 0x004 alone: p0_ready=1 in cycle 0, p0_rvalid=1 in cycle 1 with p0_rdata equal to the word, busy=1 in cycle 1.
REQ-035 p0 and p1 SW requests every cycle after reset: grants alternate p0, p1, p0, p1, with mem_write=1 each cycle.
REQ-036 With ROUND_ROBIN=0 and both ports continuously loading: only p0 receives ready, and p1_ready stays 0.
REQ-037 p1 SB 0xA5 to 0x003, then p0 LBU from 0x003: p0_rdata=0x000000A5; p0 LB from 0x003 gives 0xFFFFFFA5.
REQ-038 p1 load accepted, rst_n pulsed low in RD_WAIT: no rvalid, busy=0 immediately, and the next tie is granted to p0.
REQ-039 p0 request raised during p1's RD_WAIT: p0_ready held 0 that cycle and asserted 1 in the next cycle.
